pipe_stage_reg: RTL

- Parametrised successor to the fixed decode-to-execute pipeline register.
- Carries a DW-bit payload between any two core stages using a valid/ready handshake, not a global hold flag.
- Contains a 2-entry skid buffer so the ready path is fully registered, plus a flush input that inserts a bubble.
- Instantiated between IF/ID/EX/MEM stages, with the stage payload concatenated by the parent.

---
 rtl/pipe_stage_reg.sv | 82 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: DW-bit payload, valid/ready handshake, 2-entry skid, flush to bubble.
// Optional back-pressure counter on stall_cnt_o when PIPE_STALL_CNT_EN is defined.
module pipe_stage_reg #(
   parameter int unsigned        DW        = 32,
   parameter logic [DW-1:0]      NOP_VALUE = DW'(32'h00000013)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          in_valid_i,
   input  logic [DW-1:0] in_data_i,
   output logic          in_ready_o,
   output logic          out_valid_o,
   output logic [DW-1:0] out_data_o,
   input  logic          out_ready_i,
   output logic [31:0]   stall_cnt_o
);

   // Handshake: a beat moves on a rising edge when valid and ready are both high
   // at that edge. Valid never depends on ready, and out_data_o is held stable
   // while out_valid_o=1 and out_ready_i=0.
   logic          skid_valid;
   logic [DW-1:0] skid_data;
   logic          push;
   logic          pop;
   logic          main_free;

   assign in_ready_o = ~skid_valid;
   assign push       = in_valid_i & in_ready_o;
   assign pop        = out_valid_o & out_ready_i;
   assign main_free  = ~out_valid_o | pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_o <= 1'b0;
         out_data_o  <= NOP_VALUE;
         skid_valid  <= 1'b0;
         skid_data   <= NOP_VALUE;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= NOP_VALUE;
         skid_valid  <= 1'b0;
         skid_data   <= NOP_VALUE;
      end else if (main_free) begin
         if (skid_valid) begin
            // in_ready_o was low, so no push can compete with the skid refill
            out_valid_o <= 1'b1;
            out_data_o  <= skid_data;
            skid_valid  <= 1'b0;
            skid_data   <= NOP_VALUE;
         end else if (push) begin
            out_valid_o <= 1'b1;
            out_data_o  <= in_data_i;
         end else begin
            out_valid_o <= 1'b0;
            out_data_o  <= NOP_VALUE;
         end
      end else if (push) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data_i;
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 32'h0;
      end else if (out_valid_o && !out_ready_i && !flush_i && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'h1;
      end
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = 32'h0;
`endif

   a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst) skid_valid |-> out_valid_o);

endmodule
